// File: rtl/pc_npc_unit_if.sv
// Fetch-side bus of pc_npc_unit: pipeline/branch controls in, PC pair and squash out.
// taken_count exists only when PC_BRANCH_STATS_EN is defined.
interface pc_npc_unit_if;
  logic        le;
  logic        is_branch;
  logic        is_ba;
  logic        branch_taken;
  logic        branch_annul;
  logic        jump_valid;
  logic [31:0] target;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        fetch_valid;
  logic        squash;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] taken_count;
`endif

  modport master (
    output le, is_branch, is_ba, branch_taken, branch_annul, jump_valid, target,
`ifdef PC_BRANCH_STATS_EN
    input  taken_count,
`endif
    input  pc, npc, fetch_valid, squash
  );

  modport slave (
    input  le, is_branch, is_ba, branch_taken, branch_annul, jump_valid, target,
`ifdef PC_BRANCH_STATS_EN
    output taken_count,
`endif
    output pc, npc, fetch_valid, squash
  );
endinterface

// File: rtl/pc_npc_unit.sv
// SPARC PC/nPC pair with delayed-branch redirect, annul squash and stall-held redirects.
// Optional taken-redirect counter enabled by PC_BRANCH_STATS_EN.
module pc_npc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] RESET_NPC = 32'h0000_0004
) (
  input  logic            clk,
  input  logic            reset,
  pc_npc_unit_if.slave    bus
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        pend_annul_q, pend_annul_d;
  logic        squash_q, squash_d;
  logic        fetch_valid_q;
  logic        redirect;
  logic        annul;
  logic [31:0] eff_target;

  assign redirect   = (bus.is_branch & bus.branch_taken) | bus.jump_valid;
  assign annul      = bus.is_branch & bus.branch_annul & (~bus.branch_taken | bus.is_ba);
  assign eff_target = bus.target & 32'hFFFF_FFFC;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    npc_d         = npc_q;
    squash_d      = squash_q;
    pend_target_d = pend_target_q;
    pend_annul_d  = pend_annul_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.le) begin
          pc_d     = npc_q;
          npc_d    = redirect ? eff_target : npc_q + 32'd4;
          squash_d = annul;
        end else if (redirect) begin
          pend_target_d = eff_target;
          pend_annul_d  = annul;
          state_d       = PEND;
        end
      end
      PEND: begin
        // Only the first redirect captured during the stall is applied.
        if (bus.le) begin
          pc_d     = npc_q;
          npc_d    = pend_target_q;
          squash_d = pend_annul_q;
          state_d  = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      npc_q         <= RESET_NPC;
      squash_q      <= 1'b0;
      fetch_valid_q <= 1'b0;
      pend_target_q <= '0;
      pend_annul_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      npc_q         <= npc_d;
      squash_q      <= squash_d;
      fetch_valid_q <= 1'b1;
      pend_target_q <= pend_target_d;
      pend_annul_q  <= pend_annul_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.npc         = npc_q;
  assign bus.squash      = squash_q;
  assign bus.fetch_valid = fetch_valid_q;

`ifdef PC_BRANCH_STATS_EN
  logic [15:0] taken_count_q;
  logic        load_redirect;

  assign load_redirect = bus.le & (((state_q == RUN) & redirect) | (state_q == PEND));

  always_ff @(posedge clk) begin
    if (reset)
      taken_count_q <= '0;
    else if (load_redirect && (taken_count_q != '1))
      taken_count_q <= taken_count_q + 16'd1;
  end

  assign bus.taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_pc_npc_unit.sv
// Scoreboard bench for pc_npc_unit: directed test-plan sequences then randomized traffic,
// each cycle checked against an architectural PC/nPC model.
module tb_pc_npc_unit;

  logic clk;
  logic reset;
  pc_npc_unit_if bus ();

  pc_npc_unit #(
    .RESET_PC  (32'h0000_0000),
    .RESET_NPC (32'h0000_0004)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        sq;
    logic        fv;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [31:0] tgt;
    logic        an;
  } redir_t;

  exp_t   sb[$];
  redir_t pending[$];

  int tests  = 0;
  int failed = 0;

  // Architectural model state
  logic [31:0] m_pc, m_npc;
  logic        m_sq, m_fv;
  int unsigned m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] add4(input logic [31:0] a);
    return 32'((64'(a) + 64'd4) % 64'h1_0000_0000);
  endfunction

  function automatic void taken();
    if (m_cnt < 65535) m_cnt++;
  endfunction

  function automatic void model(input logic rst, le, isb, isba, tk, an, jv,
                                input logic [31:0] tgt);
    logic   redir, ann;
    redir_t r;
    redir = (isb && tk) || jv;
    ann   = isb && an && (!tk || isba);
    if (rst) begin
      m_pc = 32'h0; m_npc = 32'h4; m_sq = 1'b0; m_fv = 1'b0; m_cnt = 0;
      pending.delete();
    end else if (!m_fv) begin
      m_fv = 1'b1;
    end else if (pending.size() != 0) begin
      if (le) begin
        r = pending.pop_front();
        m_pc = m_npc; m_npc = r.tgt; m_sq = r.an;
        taken();
      end
    end else if (le) begin
      m_pc  = m_npc;
      m_npc = redir ? {tgt[31:2], 2'b00} : add4(m_npc);
      m_sq  = ann;
      if (redir) taken();
    end else if (redir) begin
      r.tgt = {tgt[31:2], 2'b00};
      r.an  = ann;
      pending.push_back(r);
    end
  endfunction

  // Called at a negedge; applies inputs across one posedge and returns at the next negedge.
  task automatic step(input logic rst, le, isb, isba, tk, an, jv, input logic [31:0] tgt);
    exp_t e;
    reset = rst; bus.le = le; bus.is_branch = isb; bus.is_ba = isba;
    bus.branch_taken = tk; bus.branch_annul = an; bus.jump_valid = jv; bus.target = tgt;
    @(posedge clk);
    model(rst, le, isb, isba, tk, an, jv, tgt);
    e.pc = m_pc; e.npc = m_npc; e.sq = m_sq; e.fv = m_fv; e.cnt = 16'(m_cnt);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input logic le);
    step(1'b0, le, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic jump(input logic le, input logic [31:0] tgt);
    step(1'b0, le, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tgt);
  endtask

  // Monitor: every edge the DUT presents a new registered state
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pc", bus.pc, e.pc);
        chk("npc", bus.npc, e.npc);
        chk("squash", {31'b0, bus.squash}, {31'b0, e.sq});
        chk("fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, e.fv});
`ifdef PC_BRANCH_STATS_EN
        chk("taken_count", {16'b0, bus.taken_count}, {16'b0, e.cnt});
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef PC_BRANCH_STATS_EN
    logic [15:0] cnt0;
`endif
    reset = 1'b1; bus.le = 1'b0; bus.is_branch = 1'b0; bus.is_ba = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_annul = 1'b0; bus.jump_valid = 1'b0;
    bus.target = '0;
    m_pc = '0; m_npc = '0; m_sq = 1'b0; m_fv = 1'b0; m_cnt = 0;
    @(negedge clk);

    // Reset and BOOT
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_npc", bus.npc, 32'h4);
    chk("rst_fv", {31'b0, bus.fetch_valid}, 32'h0);
    idle(1'b1);
    chk("boot_npc", bus.npc, 32'h4);
    chk("boot_fv", {31'b0, bus.fetch_valid}, 32'h1);
    idle(1'b1);
    chk("run_pc", bus.pc, 32'h4);
    chk("run_npc", bus.npc, 32'h8);
    idle(1'b1);

    // Taken conditional branch with a=1: slot executes
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40);
    chk("tb_npc", bus.npc, 32'h40);
    chk("tb_squash", {31'b0, bus.squash}, 32'h0);
    idle(1'b1);
    chk("tb_pc", bus.pc, 32'h40);

    // Untaken annulled branch from pc=8
    jump(1'b1, 32'h8);
    idle(1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h77);
    chk("ua_pc", bus.pc, 32'hC);
    chk("ua_npc", bus.npc, 32'h10);
    chk("ua_squash", {31'b0, bus.squash}, 32'h1);
    idle(1'b1);
    chk("ua_clear", {31'b0, bus.squash}, 32'h0);

    // ba,a with unaligned target
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h103);
    chk("ba_npc", bus.npc, 32'h100);
    chk("ba_squash", {31'b0, bus.squash}, 32'h1);

    // Stalled redirect: first capture wins
`ifdef PC_BRANCH_STATS_EN
    cnt0 = bus.taken_count;
`endif
    jump(1'b0, 32'h200);
    jump(1'b0, 32'h300);
    chk("stall_hold_sq", {31'b0, bus.squash}, 32'h1);
    idle(1'b1);
    chk("stall_npc", bus.npc, 32'h200);
    chk("stall_squash", {31'b0, bus.squash}, 32'h0);
`ifdef PC_BRANCH_STATS_EN
    chk("stall_cnt", {16'b0, bus.taken_count}, {16'b0, cnt0 + 16'd1});
`endif

    // Wrap-around, then reset while a redirect is pending
    jump(1'b1, 32'hFFFF_FFFC);
    idle(1'b1);
    chk("wrap_npc", bus.npc, 32'h0);
    jump(1'b0, 32'h500);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("prst_pc", bus.pc, 32'h0);
    chk("prst_npc", bus.npc, 32'h4);
    idle(1'b1);
    idle(1'b1);
    chk("prst_pc2", bus.pc, 32'h4);
    chk("prst_npc2", bus.npc, 32'h8);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      step($urandom_range(63) == 0, $urandom_range(99) < 65,
           1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(1)), $urandom_range(7) == 0, t);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pc_npc_unit.md
# pc_npc_unit

- Holds the SPARC program counter pair (PC, nPC) and applies delayed-branch semantics.
- Consumes the branch/call target produced by the displacement ×4 and adder32Bit path, and feeds PC to instruction fetch.
- Raises a registered `squash` that kills an annulled delay-slot instruction.
- Holds a redirect that arrives during a pipeline stall until the stall clears.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded by reset
- `RESET_NPC`, 32'h0000_0004, nPC value loaded by reset

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high; reset is synchronous and active-high, sampled on `clk` rising edge only
- `le`  in  1  load enable; 1 = pipeline advances this cycle, 0 = stall
- `is_branch`  in  1  ID holds a conditional branch (Bicc)
- `is_ba`  in  1  that branch is branch-always; qualified by `is_branch`
- `branch_taken`  in  1  condition evaluated true; qualified by `is_branch`
- `branch_annul`  in  1  the instruction's a-bit
- `jump_valid`  in  1  ID holds CALL/JMPL; unconditional redirect, never annuls
- `target`  in  32  redirect address from the target adder
- `pc`  out  32  current fetch address
- `npc`  out  32  next fetch address
- `fetch_valid`  out  1  0 in the BOOT cycle, 1 otherwise
- `squash`  out  1  kill the instruction fetched from the current `pc` (annulled delay slot)
- `taken_count`  out  16  present only with `PC_BRANCH_STATS_EN`

## Operation
- `redirect = (is_branch & branch_taken) | jump_valid`.
- `annul = is_branch & branch_annul & (~branch_taken | is_ba)`.
  - Conditional branch, a=1, not taken: slot annulled.
  - `ba,a`: slot annulled.
  - `jump_valid` never sets `annul`.
- Effective target is `{target[31:2], 2'b00}`.
- Sequential increment is `npc + 4`, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.

FSM states are BOOT, RUN and PEND.
- **reset** (any state): BOOT; `pc=RESET_PC`, `npc=RESET_NPC`, `squash=0`, `fetch_valid=0`, pend regs=0, `taken_count=0`. Reset overrides every other input in that cycle.
- **BOOT**: go to RUN next cycle unconditionally. `pc`/`npc` unchanged. `fetch_valid` goes to 1. All other inputs ignored.
- **RUN**, `le=1`:
  - `pc<=npc`
  - `npc <= redirect ? eff_target : npc+4`
  - `squash<=annul`
- **RUN**, `le=0`, `redirect=1`:
  - capture `pend_target<=eff_target`, `pend_annul<=annul`
  - go to PEND
  - `pc`/`npc`/`squash` hold
- **RUN**, `le=0`, `redirect=0`: everything holds.
- **PEND**, `le=0`: hold. New redirect/annul inputs are ignored; the first captured redirect wins.
- **PEND**, `le=1`:
  - `pc<=npc`, `npc<=pend_target`, `squash<=pend_annul`
  - go to RUN
  - Live inputs that cycle are ignored.
- `squash` is cleared on any `le=1` update that carries no annul. It holds its value while stalled.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- A redirect sampled with `le=1` appears on `npc` after 1 cycle, and on `pc` at the next `le=1` edge (one delay slot).
- A redirect sampled during a stall appears on `npc` at the first edge with `le=1`, i.e. latency = stall length + 1.
- `squash` is valid in the same cycle that `pc` addresses the delay slot, i.e. 1 cycle after the annulling branch is sampled.
- Reset mid-stall or in PEND discards the pending redirect.

## Configuration
- Macro: `PC_BRANCH_STATS_EN`.
- Defined:
  - `taken_count` port exists.
  - It increments by 1 on every edge where `npc` is loaded from a redirect (RUN with `le=1`, or PEND with `le=1`).
  - It saturates at 16'hFFFF and resets to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- **Reset and BOOT:** reset high 2 cycles, then low → `pc=0`, `npc=4`, `fetch_valid=0` for 1 cycle; then `le=1` gives `pc=4`, `npc=8`, `fetch_valid=1`.
- **Taken branch, no annul:** from `pc=8`, `npc=C`: `is_branch=1`, `branch_taken=1`, `branch_annul=1`, `target=40`, `le=1` → `npc=40`, `squash=0`; next `le=1` → `pc=40`.
- **Untaken annulled branch:** `is_branch=1`, `branch_taken=0`, `branch_annul=1`, `pc=8`, `npc=C` → `npc=10`, `pc=C`, `squash=1`; next `le=1` clears `squash`.
- **Branch-always annulled:** `is_ba=1`, `branch_annul=1`, `target=103` → `npc=100` (low bits cleared) and `squash=1`.
- **Stalled redirect:** `le=0` with `jump_valid=1`, `target=200`, then a second redirect `target=300` during the stall, then `le=1` → `npc=200`, `squash=0`. With the macro, `taken_count` increments by exactly 1.
- **Wrap-around and reset during PEND:** `npc=FFFF_FFFC`, `le=1`, no redirect → `npc=0`. Enter PEND, assert reset → `pc=RESET_PC`, `npc=RESET_NPC`, and the pending target is never applied.
